// File: rtl/dsp_sched_pkg.sv
// Shared widths, FSM state encoding and operand-pack layout for the SOP chain scheduler.
`default_nettype none

package dsp_sched_pkg;

   localparam int OP_W  = 74;
   localparam int RES_W = 37;

   // One stage's operand word is {by, ay, bx, ax}, LSB first.
   localparam int AX_LSB = 0;
   localparam int AX_W   = 18;
   localparam int BX_LSB = 18;
   localparam int BX_W   = 18;
   localparam int AY_LSB = 36;
   localparam int AY_W   = 19;
   localparam int BY_LSB = 55;
   localparam int BY_W   = 19;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

   function automatic logic [OP_W-1:0] pack_ops(input logic [AX_W-1:0] ax,
                                                 input logic [BX_W-1:0] bx,
                                                 input logic [AY_W-1:0] ay,
                                                 input logic [BY_W-1:0] by);
      return {by, ay, bx, ax};
   endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_chain_sop_sched_if.sv
// Requester and result handshake bundle; the scheduler sits on the slave modport.
`default_nettype none

interface dsp_chain_sop_sched_if
   import dsp_sched_pkg::*;
#(
   parameter int CHAIN_LEN = 4
) ();

   logic [1:0]                req_valid;
   logic [1:0]                req_ready;
   logic [OP_W*CHAIN_LEN-1:0] req0_ops;
   logic [OP_W*CHAIN_LEN-1:0] req1_ops;
   logic                      res_valid;
   logic                      res_ready;
   logic [RES_W-1:0]          res_data;
   logic                      res_id;

   modport master (
      output req_valid, req0_ops, req1_ops, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
      input  req_valid, req0_ops, req1_ops, res_ready,
      output req_ready, res_valid, res_data, res_id
   );

endinterface

`default_nettype wire

// File: rtl/dsp_sched_fifo.sv
// Result buffer: power-of-two circular FIFO with occupancy count and zeroed read data when empty.
`default_nettype none

module dsp_sched_fifo #(
   parameter int  WIDTH = 38,
   parameter int  DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is still taken when the head leaves in the same cycle.
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/dsp_chain_sop_sched.sv
// Two-requester round-robin scheduler feeding a skewed int_sop_2 chain and buffering its results.
// Define DSP_SOP_SCHED_PERF_EN to add per-requester saturating grant counters (perf_cnt0/perf_cnt1).
`default_nettype none

module dsp_chain_sop_sched
   import dsp_sched_pkg::*;
#(
   parameter int CHAIN_LEN  = 4,
   parameter int RES_LAT    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sched_en,
   dsp_chain_sop_sched_if.slave      bus,
   output logic [OP_W*CHAIN_LEN-1:0] dsp_ops,
   input  logic [RES_W-1:0]          chain_result,
   output logic                      busy
`ifdef DSP_SOP_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_cnt0,
   output logic [31:0]               perf_cnt1
`endif
);

   localparam int TAG_LEN = CHAIN_LEN + RES_LAT;
   localparam int INFL_W  = $clog2(CHAIN_LEN + RES_LAT + 2);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   sched_state_e              state_q, state_d;
   logic                      prio_q, prio_d;
   logic [TAG_LEN-1:0]        tag_vld_q, tag_vld_d;
   logic [TAG_LEN-1:0]        tag_id_q, tag_id_d;
   logic [INFL_W-1:0]         inflight_q, inflight_d;
   logic [CNT_W-1:0]          fifo_count;
   logic                      fifo_empty;
   logic                      credit_ok;
   logic                      can_issue;
   logic [1:0]                grant;
   logic                      issue;
   logic                      issue_id;
   logic                      capture;
   logic [OP_W*CHAIN_LEN-1:0] ops_sel;

   // Every in-flight job already owns a buffer slot, so the chain never needs back-pressure.
   assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
   assign can_issue = (state_q == ST_RUN) && sched_en && credit_ok;

   always_comb begin
      grant = 2'b00;
      if (can_issue) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign issue         = |grant;
   assign issue_id      = grant[1];
   assign bus.req_ready = grant;
   assign ops_sel       = issue_id ? bus.req1_ops : bus.req0_ops;
   assign capture       = tag_vld_q[TAG_LEN-1];

   always_comb begin
      state_d    = state_q;
      prio_d     = issue ? ~issue_id : prio_q;
      tag_vld_d  = {tag_vld_q[TAG_LEN-2:0], issue};
      tag_id_d   = {tag_id_q[TAG_LEN-2:0], issue_id};
      inflight_d = inflight_q;
      case ({issue, capture})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
      case (state_q)
         ST_IDLE:  if (sched_en) state_d = ST_RUN;
         ST_RUN:   if (!sched_en) state_d = (inflight_q != '0) ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: begin
            if (sched_en)                state_d = ST_RUN;
            else if (inflight_q == '0)   state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         prio_q     <= 1'b0;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
         inflight_q <= inflight_d;
      end
   end

   // Stage k sees its operands k cycles after stage 0, matching the chain's cascade latency.
   for (genvar k = 0; k < CHAIN_LEN; k++) begin : g_stage
      logic [OP_W-1:0] skew_q [k+1];
      logic [OP_W-1:0] skew_d [k+1];

      always_comb begin
         skew_d[0] = issue ? ops_sel[k*OP_W +: OP_W] : '0;
         for (int j = 1; j <= k; j++) begin
            skew_d[j] = skew_q[j-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            skew_q <= '{default: '0};
         end else begin
            skew_q <= skew_d;
         end
      end

      assign dsp_ops[k*OP_W +: OP_W] = skew_q[k];
   end

   dsp_sched_fifo #(
      .WIDTH (RES_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .wdata ({tag_id_q[TAG_LEN-1], chain_result}),
      .pop   (bus.res_valid && bus.res_ready),
      .rdata ({bus.res_id, bus.res_data}),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.res_valid = !fifo_empty;
   assign busy          = (inflight_q != '0) || !fifo_empty;

`ifdef DSP_SOP_SCHED_PERF_EN
   logic [31:0] perf_cnt0_q, perf_cnt0_d;
   logic [31:0] perf_cnt1_q, perf_cnt1_d;

   always_comb begin
      perf_cnt0_d = perf_cnt0_q;
      perf_cnt1_d = perf_cnt1_q;
      if (grant[0] && (perf_cnt0_q != '1)) perf_cnt0_d = perf_cnt0_q + 1'b1;
      if (grant[1] && (perf_cnt1_q != '1)) perf_cnt1_d = perf_cnt1_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt0_q <= '0;
         perf_cnt1_q <= '0;
      end else begin
         perf_cnt0_q <= perf_cnt0_d;
         perf_cnt1_q <= perf_cnt1_d;
      end
   end

   assign perf_cnt0 = perf_cnt0_q;
   assign perf_cnt1 = perf_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsp_chain_sop_sched.sv
// Directed bench for dsp_chain_sop_sched with a behavioural 4-stage SOP chain (sum of ax*ay+bx*by).
`default_nettype none

module tb_dsp_chain_sop_sched;
   import dsp_sched_pkg::*;

   localparam int CL    = 4;
   localparam int RL    = 3;
   localparam int FD    = 8;
   localparam int OPS_W = OP_W * CL;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sched_en;
   logic [OPS_W-1:0] dsp_ops;
   logic [RES_W-1:0] chain_result;
   logic             busy;
`ifdef DSP_SOP_SCHED_PERF_EN
   logic [31:0]      perf_cnt0;
   logic [31:0]      perf_cnt1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   dsp_chain_sop_sched_if #(.CHAIN_LEN(CL)) bus ();

   dsp_chain_sop_sched #(
      .CHAIN_LEN  (CL),
      .RES_LAT    (RL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sched_en     (sched_en),
      .bus          (bus.slave),
      .dsp_ops      (dsp_ops),
      .chain_result (chain_result),
      .busy         (busy)
`ifdef DSP_SOP_SCHED_PERF_EN
      ,
      .perf_cnt0    (perf_cnt0),
      .perf_cnt1    (perf_cnt1)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural chain: stage k adds its product to stage k-1's partial, then RES_LAT-1 output regs.
   logic [RES_W-1:0] part_q [CL];
   logic [RES_W-1:0] lat_q  [RL-1];

   function automatic logic [RES_W-1:0] sop(input logic [OP_W-1:0] o);
      logic signed [17:0]      ax, bx;
      logic signed [18:0]      ay, by;
      logic signed [RES_W-1:0] p1, p2;
      ax = o[17:0];
      bx = o[35:18];
      ay = o[54:36];
      by = o[73:55];
      p1 = ax * ay;
      p2 = bx * by;
      return p1 + p2;
   endfunction

   always @(posedge clk) begin
      part_q[0] <= sop(dsp_ops[OP_W-1:0]);
      for (int k = 1; k < CL; k++) part_q[k] <= part_q[k-1] + sop(dsp_ops[k*OP_W +: OP_W]);
      lat_q[0] <= part_q[CL-1];
      for (int i = 1; i < RL-1; i++) lat_q[i] <= lat_q[i-1];
   end
   assign chain_result = lat_q[RL-2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OPS_W-1:0] rep(input logic [OP_W-1:0] o);
      return {CL{o}};
   endfunction

   task automatic do_reset();
      rst_n         = 1'b0;
      sched_en      = 1'b0;
      bus.req_valid = 2'b00;
      bus.req0_ops  = '0;
      bus.req1_ops  = '0;
      bus.res_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic start_run();
      sched_en = 1'b1;
      tick();
   endtask

   task automatic wait_res(input string tag, input logic [RES_W-1:0] ed, input logic ei);
      int i;
      i = 0;
      while (!bus.res_valid && i < 40) begin
         tick();
         i++;
      end
      chk({tag, " valid"}, 64'(bus.res_valid), 64'd1);
      chk({tag, " data"}, 64'(bus.res_data), 64'(ed));
      chk({tag, " id"}, 64'(bus.res_id), 64'(ei));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [OP_W-1:0]  p;
      logic [OPS_W-1:0] ev;
      logic [OPS_W-1:0] v0, v1;
      int               cyc, grants, seen;
      logic [RES_W-1:0] held;

      // Reset state, with requests pending to prove req_ready is masked
      rst_n         = 1'b0;
      sched_en      = 1'b1;
      bus.req_valid = 2'b11;
      bus.req0_ops  = rep(pack_ops(18'd1, 18'd1, 19'd2, 19'd2));
      bus.req1_ops  = rep(pack_ops(18'd1, 18'd1, 19'd2, 19'd2));
      bus.res_ready = 1'b1;
      tick();
      tick();
      chk("rst res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst res_data", 64'(bus.res_data), 64'd0);
      chk("rst res_id", 64'(bus.res_id), 64'd0);
      chk("rst dsp_ops zero", 64'(dsp_ops == '0), 64'd1);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst req_ready", 64'(bus.req_ready), 64'd0);

      // Single job from requester 0: 4 stages of 1*2+1*2 -> 16
      do_reset();
      start_run();
      p = pack_ops(18'd1, 18'd1, 19'd2, 19'd2);
      bus.req0_ops  = rep(p);
      bus.req_valid = 2'b01;
      #1;
      chk("t1 grant", 64'(bus.req_ready), 64'd1);
      tick();
      bus.req_valid = 2'b00;
      for (int k = 0; k < CL; k++) begin
         ev = '0;
         ev[k*OP_W +: OP_W] = p;
         chk("t1 skew", 64'(dsp_ops == ev), 64'd1);
         tick();
      end
      // Issue cycle is 0; capture at the end of cycle 7, so res_valid shows in cycle 8
      cyc = 1 + CL;
      while (!bus.res_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("t1 result cycle", 64'(cyc), 64'(CL + RL + 1));
      chk("t1 data", 64'(bus.res_data), 64'd16);
      chk("t1 id", 64'(bus.res_id), 64'd0);
      tick();
      chk("t1 busy after pop", 64'(busy), 64'd0);

      // Alternating grants; req0 sums 2*(1+2+3+4)=20, req1 sums 3*4+(0+1+2+3)=18
      do_reset();
      start_run();
      for (int k = 0; k < CL; k++) begin
         v0[k*OP_W +: OP_W] = pack_ops(18'(k + 1), 18'd0, 19'd2, 19'd0);
         v1[k*OP_W +: OP_W] = pack_ops(18'd1, 18'd1, 19'd3, 19'(k));
      end
      bus.req0_ops  = v0;
      bus.req1_ops  = v1;
      bus.req_valid = 2'b11;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t2 rr grant", 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
         tick();
      end
      bus.req_valid = 2'b00;
      for (int i = 0; i < 8; i++) begin
         wait_res("t2 res", (i % 2 == 0) ? 37'd20 : 37'd18, logic'(i % 2));
      end

      // Consumer stalled: credits limit issue to FIFO_DEPTH jobs
      do_reset();
      bus.res_ready = 1'b0;
      start_run();
      bus.req0_ops  = rep(pack_ops(18'd1, 18'd1, 19'd2, 19'd2));
      bus.req_valid = 2'b01;
      grants = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (bus.req_ready[0]) grants++;
         tick();
      end
      chk("t3 grants", 64'(grants), 64'(FD));
      chk("t3 credit stall", 64'(bus.req_ready), 64'd0);
      held = bus.res_data;
      tick();
      chk("t3 hold valid", 64'(bus.res_valid), 64'd1);
      chk("t3 hold data", 64'(bus.res_data), 64'(held));
      bus.req_valid = 2'b00;
      bus.res_ready = 1'b1;
      for (int i = 0; i < FD; i++) wait_res("t3 res", 37'd16, 1'b0);
      tick();
      chk("t3 empty", 64'(bus.res_valid), 64'd0);
      chk("t3 busy", 64'(busy), 64'd0);

      // Drain: 3 jobs of 2*5+1*1 per stage -> 44, then sched_en drops
      do_reset();
      start_run();
      bus.req1_ops  = rep(pack_ops(18'd2, 18'd1, 19'd5, 19'd1));
      bus.req_valid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4 grant", 64'(bus.req_ready), 64'd2);
         tick();
      end
      sched_en = 1'b0;
      #1;
      chk("t4 no grant when off", 64'(bus.req_ready), 64'd0);
      tick();
      chk("t4 drain state", 64'(dut.state_q), 64'(ST_DRAIN));
      chk("t4 drain ready", 64'(bus.req_ready), 64'd0);
      for (int i = 0; i < 3; i++) wait_res("t4 res", 37'd44, 1'b1);
      chk("t4 idle state", 64'(dut.state_q), 64'(ST_IDLE));
      chk("t4 busy", 64'(busy), 64'd0);
      bus.req_valid = 2'b00;

      // Reset two cycles after an issue discards the job
      do_reset();
      start_run();
      bus.req0_ops  = rep(pack_ops(18'd1, 18'd1, 19'd2, 19'd2));
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      tick();
      tick();
      bus.req_valid = 2'b01;
      rst_n = 1'b0;
      #1;
      chk("t5 res_valid", 64'(bus.res_valid), 64'd0);
      chk("t5 res_data", 64'(bus.res_data), 64'd0);
      chk("t5 dsp_ops zero", 64'(dsp_ops == '0), 64'd1);
      chk("t5 busy", 64'(busy), 64'd0);
      chk("t5 req_ready", 64'(bus.req_ready), 64'd0);
      tick();
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.res_valid) seen++;
         tick();
      end
      chk("t5 no stale result", 64'(seen), 64'd0);

`ifdef DSP_SOP_SCHED_PERF_EN
      do_reset();
      start_run();
      bus.req_valid = 2'b10;
      for (int i = 0; i < 5; i++) tick();
      bus.req_valid = 2'b00;
      tick();
      chk("perf cnt1", 64'(perf_cnt1), 64'd5);
      chk("perf cnt0", 64'(perf_cnt0), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
